csr_regfile_wb: RTL and testbench
=================================

Name: csr_regfile_wb

Overview:
- Machine-mode CSR register file feeding the decode-stage CSR index decoder.
- Holds mstatus, mtvec, mepc and mcause.
- Serves combinational reads by the 2-bit index that decode produces, and commits CSR writes, ecall and mret from writeback.
- After a committed ecall or mret, issues a held redirect to the fetch unit through a valid/ready handshake.

Parameters:
- XLEN, 32, width of every CSR and of the pc.
- MSTATUS_RST, 32'h0000_1800, reset value of mstatus (MPP=2'b11).
- MTVEC_RST, 32'h0, reset value of mtvec.
- MCAUSE_ECALL, 32'd11, value written to mcause on ecall (environment call from M-mode).

Ports:
- clk  in  1  system clock
- rst  in  1  reset; asynchronous, active-high
- IDU_csr_rs  in  2  read index from decode (0=mstatus, 1=mtvec, 2=mepc, 3=mcause)
- IDU_csr_rdata  out  XLEN  read data for IDU_csr_rs; combinational
- WB_valid  in  1  writeback beat valid
- WB_ready  out  1  CSR file accepts the writeback beat
- WB_csr_wen  in  1  explicit CSR write (csrrw/csrrs/csrrc result)
- WB_csr_rd  in  2  write index, same encoding as IDU_csr_rs
- WB_csr_wdata  in  XLEN  write data
- WB_ecall  in  1  committing instruction is ecall
- WB_mret  in  1  committing instruction is mret
- WB_pc  in  XLEN  pc of the committing instruction
- CSR_redirect_valid  out  1  redirect request to fetch
- CSR_redirect_pc  out  XLEN  redirect target
- IFU_redirect_ready  in  1  fetch accepts the redirect

Behaviour:
- Reset (async, rst=1):
  - mstatus=MSTATUS_RST; mtvec=MTVEC_RST; mepc=0; mcause=0.
  - FSM=IDLE; CSR_redirect_valid=0; CSR_redirect_pc=0; WB_ready=1.
  - IDU_csr_rdata=MSTATUS_RST when rs=0.
  - Reset mid-redirect drops the request immediately.
- Commit: fire = WB_valid & WB_ready. CSR state changes only on the rising edge after fire.
- Priority within one fire beat: ecall > mret > WB_csr_wen.
  - WB_csr_wen is ignored when ecall or mret is set.
  - ecall with mret both set is illegal; ecall wins.
- ecall fire:
  - mepc<=WB_pc; mcause<=MCAUSE_ECALL.
  - mstatus.MPIE(bit7)<=MIE(bit3); MIE<=0; MPP(bits12:11)<=2'b11.
  - Next FSM=REDIRECT; CSR_redirect_pc<=current mtvec.
- mret fire:
  - MIE<=MPIE; MPIE<=1; MPP<=2'b11.
  - Next FSM=REDIRECT; CSR_redirect_pc<=current mepc.
- Plain write fire: register[WB_csr_rd]<=WB_csr_wdata, full XLEN, no field masking. FSM stays IDLE.
- FSM states:
  - IDLE: WB_ready=1, CSR_redirect_valid=0.
  - REDIRECT: WB_ready=0, CSR_redirect_valid=1, CSR_redirect_pc stable.
  - REDIRECT->IDLE on the edge where IFU_redirect_ready=1. Ready may be high in the first REDIRECT cycle (one-cycle pulse).
- Latency:
  - Redirect is visible 1 cycle after the ecall/mret fire.
  - Writeback is blocked for ≥1 cycle per trap.
  - Write-to-read visibility is 1 cycle (without bypass).
- Read port is purely combinational on IDU_csr_rs and current register state. All 4 index values are legal.

Optional Feature:
- Macro: CSR_WB_BYPASS_EN.
- Defined: IDU_csr_rdata forwards the value being committed on a fire beat when the read index matches the updated register:
  - plain write: WB_csr_wdata
  - ecall: WB_pc for mepc, MCAUSE_ECALL for mcause, next mstatus for mstatus
  - mret: next mstatus
- Undefined: reads always return the registered value; upstream stalls one cycle on a CSR RAW hazard.

Test Plan:
- Reset: assert rst asynchronously mid-cycle, read all 4 indices -> 32'h1800, 0, 0, 0; WB_ready=1; CSR_redirect_valid=0.
- Write: fire csr_wen rd=1 wdata=32'h8000_0100, then ecall at WB_pc=32'h8000_0040 with MIE=1 -> next cycle mepc=32'h8000_0040, mcause=11, MIE=0, MPIE=1, redirect_valid=1, redirect_pc=32'h8000_0100.
- Redirect backpressure: hold IFU_redirect_ready=0 for 3 cycles -> redirect_valid and pc stable, WB_ready=0; WB_valid with csr_wen=1 rd=0 during this window -> mstatus unchanged. Raise ready -> IDLE next cycle, WB_ready=1.
- mret: with mepc=32'h8000_0044 and mstatus=32'h1880, fire mret -> redirect_pc=32'h8000_0044, mstatus=32'h1888.
- Priority: fire ecall with csr_wen=1 rd=3 wdata=32'hdead_beef -> mcause=11, not 32'hdead_beef.
- Bypass: fire csr_wen rd=2 wdata=32'h1234 while IDU_csr_rs=2 -> rdata=32'h1234 in the same cycle with CSR_WB_BYPASS_EN; previous mepc without it.

Source files
------------

// File: rtl/csr_regfile_wb.sv
// Machine-mode CSR file (mstatus/mtvec/mepc/mcause): combinational decode read, writeback commit, trap redirect.
// Optional macro CSR_WB_BYPASS_EN forwards the value being committed on a fire beat to the read port.
module csr_regfile_wb #(
   parameter int unsigned     XLEN         = 32,
   parameter logic [XLEN-1:0] MSTATUS_RST  = 32'h0000_1800,
   parameter logic [XLEN-1:0] MTVEC_RST    = 32'h0,
   parameter logic [XLEN-1:0] MCAUSE_ECALL = 32'd11
) (
   input  logic            clk,
   input  logic            rst,
   input  logic [1:0]      IDU_csr_rs,
   output logic [XLEN-1:0] IDU_csr_rdata,
   input  logic            WB_valid,
   output logic            WB_ready,
   input  logic            WB_csr_wen,
   input  logic [1:0]      WB_csr_rd,
   input  logic [XLEN-1:0] WB_csr_wdata,
   input  logic            WB_ecall,
   input  logic            WB_mret,
   input  logic [XLEN-1:0] WB_pc,
   output logic            CSR_redirect_valid,
   output logic [XLEN-1:0] CSR_redirect_pc,
   input  logic            IFU_redirect_ready
);

   typedef enum logic [0:0] {
      IDLE     = 1'b0,
      REDIRECT = 1'b1
   } state_t;

   localparam logic [1:0] IDX_MSTATUS = 2'd0;
   localparam logic [1:0] IDX_MTVEC   = 2'd1;
   localparam logic [1:0] IDX_MEPC    = 2'd2;
   localparam logic [1:0] IDX_MCAUSE  = 2'd3;

   state_t          state, state_nxt;
   logic [XLEN-1:0] mstatus, mtvec, mepc, mcause;
   logic [XLEN-1:0] mstatus_nxt, mtvec_nxt, mepc_nxt, mcause_nxt;
   logic [XLEN-1:0] redirect_pc_nxt;
   logic            fire, do_ecall, do_mret, do_wr;

   // Trap entry: stack MIE into MPIE, disable interrupts, previous privilege is M.
   function automatic logic [XLEN-1:0] mstatus_on_ecall(input logic [XLEN-1:0] m);
      logic [XLEN-1:0] r;
      r        = m;
      r[7]     = m[3];
      r[3]     = 1'b0;
      r[12:11] = 2'b11;
      return r;
   endfunction

   function automatic logic [XLEN-1:0] mstatus_on_mret(input logic [XLEN-1:0] m);
      logic [XLEN-1:0] r;
      r        = m;
      r[3]     = m[7];
      r[7]     = 1'b1;
      r[12:11] = 2'b11;
      return r;
   endfunction

   assign fire     = WB_valid & WB_ready;
   assign do_ecall = fire & WB_ecall;
   assign do_mret  = fire & WB_mret & ~WB_ecall;
   assign do_wr    = fire & WB_csr_wen & ~WB_ecall & ~WB_mret;

   always_comb begin
      mstatus_nxt     = mstatus;
      mtvec_nxt       = mtvec;
      mepc_nxt        = mepc;
      mcause_nxt      = mcause;
      redirect_pc_nxt = CSR_redirect_pc;
      if (do_ecall) begin
         mstatus_nxt     = mstatus_on_ecall(mstatus);
         mepc_nxt        = WB_pc;
         mcause_nxt      = MCAUSE_ECALL;
         redirect_pc_nxt = mtvec;
      end else if (do_mret) begin
         mstatus_nxt     = mstatus_on_mret(mstatus);
         redirect_pc_nxt = mepc;
      end else if (do_wr) begin
         case (WB_csr_rd)
            IDX_MSTATUS: mstatus_nxt = WB_csr_wdata;
            IDX_MTVEC:   mtvec_nxt   = WB_csr_wdata;
            IDX_MEPC:    mepc_nxt    = WB_csr_wdata;
            default:     mcause_nxt  = WB_csr_wdata;
         endcase
      end
   end

   // Commit stage: architectural CSR state and held redirect target
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         mstatus         <= MSTATUS_RST;
         mtvec           <= MTVEC_RST;
         mepc            <= '0;
         mcause          <= '0;
         CSR_redirect_pc <= '0;
      end else begin
         mstatus         <= mstatus_nxt;
         mtvec           <= mtvec_nxt;
         mepc            <= mepc_nxt;
         mcause          <= mcause_nxt;
         CSR_redirect_pc <= redirect_pc_nxt;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) state <= IDLE;
      else     state <= state_nxt;
   end

   always_comb begin
      state_nxt          = state;
      WB_ready           = 1'b0;
      CSR_redirect_valid = 1'b0;
      case (state)
         IDLE: begin
            WB_ready = 1'b1;
            if (do_ecall || do_mret) state_nxt = REDIRECT;
         end
         REDIRECT: begin
            CSR_redirect_valid = 1'b1;
            if (IFU_redirect_ready) state_nxt = IDLE;
         end
         default: state_nxt = IDLE;
      endcase
   end

`ifdef CSR_WB_BYPASS_EN
   // Next-state values equal current state on non-fire beats, so this is a pure forward.
   always_comb begin
      case (IDU_csr_rs)
         IDX_MSTATUS: IDU_csr_rdata = mstatus_nxt;
         IDX_MTVEC:   IDU_csr_rdata = mtvec_nxt;
         IDX_MEPC:    IDU_csr_rdata = mepc_nxt;
         default:     IDU_csr_rdata = mcause_nxt;
      endcase
   end
`else
   always_comb begin
      case (IDU_csr_rs)
         IDX_MSTATUS: IDU_csr_rdata = mstatus;
         IDX_MTVEC:   IDU_csr_rdata = mtvec;
         IDX_MEPC:    IDU_csr_rdata = mepc;
         default:     IDU_csr_rdata = mcause;
      endcase
   end
`endif

endmodule

// File: tb/tb_csr_regfile_wb.sv
// Directed self-checking bench for csr_regfile_wb.
module tb_csr_regfile_wb;

   logic        clk = 1'b0;
   logic        rst = 1'b0;
   logic [1:0]  IDU_csr_rs = 2'd0;
   logic [31:0] IDU_csr_rdata;
   logic        WB_valid = 1'b0;
   logic        WB_ready;
   logic        WB_csr_wen = 1'b0;
   logic [1:0]  WB_csr_rd = 2'd0;
   logic [31:0] WB_csr_wdata = '0;
   logic        WB_ecall = 1'b0;
   logic        WB_mret = 1'b0;
   logic [31:0] WB_pc = '0;
   logic        CSR_redirect_valid;
   logic [31:0] CSR_redirect_pc;
   logic        IFU_redirect_ready = 1'b0;

   int n_chk = 0;
   int n_err = 0;

   csr_regfile_wb dut (
      .clk                (clk),
      .rst                (rst),
      .IDU_csr_rs         (IDU_csr_rs),
      .IDU_csr_rdata      (IDU_csr_rdata),
      .WB_valid           (WB_valid),
      .WB_ready           (WB_ready),
      .WB_csr_wen         (WB_csr_wen),
      .WB_csr_rd          (WB_csr_rd),
      .WB_csr_wdata       (WB_csr_wdata),
      .WB_ecall           (WB_ecall),
      .WB_mret            (WB_mret),
      .WB_pc              (WB_pc),
      .CSR_redirect_valid (CSR_redirect_valid),
      .CSR_redirect_pc    (CSR_redirect_pc),
      .IFU_redirect_ready (IFU_redirect_ready)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %h expected %h", tag, act, exp);
      end
   endtask

   task automatic rd_check(input string tag, input logic [1:0] idx, input logic [31:0] exp);
      IDU_csr_rs = idx;
      #1;
      check(tag, IDU_csr_rdata, exp);
   endtask

   // One writeback beat presented for exactly one edge, then dropped.
   task automatic wb_beat(input logic wen, input logic [1:0] rd, input logic [31:0] wdata,
                          input logic ecall, input logic mret, input logic [31:0] pc);
      WB_valid = 1'b1; WB_csr_wen = wen; WB_csr_rd = rd; WB_csr_wdata = wdata;
      WB_ecall = ecall; WB_mret = mret; WB_pc = pc;
      @(posedge clk); #1;
      WB_valid = 1'b0; WB_csr_wen = 1'b0; WB_ecall = 1'b0; WB_mret = 1'b0;
   endtask

   task automatic release_redirect(input string tag);
      IFU_redirect_ready = 1'b1;
      @(posedge clk); #1;
      IFU_redirect_ready = 1'b0;
      check({tag, "_valid_drop"}, {31'd0, CSR_redirect_valid}, 32'd0);
      check({tag, "_wb_ready"}, {31'd0, WB_ready}, 32'd1);
   endtask

   initial begin
      // Asynchronous reset asserted between clock edges
      #3 rst = 1'b1;
      #1;
      check("rst_redirect_valid", {31'd0, CSR_redirect_valid}, 32'd0);
      check("rst_wb_ready", {31'd0, WB_ready}, 32'd1);
      check("rst_redirect_pc", CSR_redirect_pc, 32'd0);
      rd_check("rst_mstatus", 2'd0, 32'h0000_1800);
      rd_check("rst_mtvec", 2'd1, 32'h0);
      rd_check("rst_mepc", 2'd2, 32'h0);
      rd_check("rst_mcause", 2'd3, 32'h0);
      @(negedge clk); rst = 1'b0;
      @(posedge clk); #1;

      // Plain writes, then ecall with MIE=1
      wb_beat(1'b1, 2'd0, 32'h0000_1808, 1'b0, 1'b0, 32'h0);
      rd_check("wr_mstatus", 2'd0, 32'h0000_1808);
      wb_beat(1'b1, 2'd1, 32'h8000_0100, 1'b0, 1'b0, 32'h0);
      rd_check("wr_mtvec", 2'd1, 32'h8000_0100);
      check("wr_no_redirect", {31'd0, CSR_redirect_valid}, 32'd0);
      wb_beat(1'b0, 2'd0, 32'h0, 1'b1, 1'b0, 32'h8000_0040);
      check("ecall_redirect_valid", {31'd0, CSR_redirect_valid}, 32'd1);
      check("ecall_redirect_pc", CSR_redirect_pc, 32'h8000_0100);
      check("ecall_wb_ready", {31'd0, WB_ready}, 32'd0);
      rd_check("ecall_mepc", 2'd2, 32'h8000_0040);
      rd_check("ecall_mcause", 2'd3, 32'd11);
      rd_check("ecall_mstatus", 2'd0, 32'h0000_1880);

      // Backpressure: writeback attempts are blocked while redirect is held
      WB_valid = 1'b1; WB_csr_wen = 1'b1; WB_csr_rd = 2'd0; WB_csr_wdata = 32'h0;
      for (int i = 0; i < 3; i++) begin
         @(posedge clk); #1;
         check("bp_valid", {31'd0, CSR_redirect_valid}, 32'd1);
         check("bp_pc", CSR_redirect_pc, 32'h8000_0100);
         check("bp_wb_ready", {31'd0, WB_ready}, 32'd0);
      end
      WB_valid = 1'b0; WB_csr_wen = 1'b0;
      rd_check("bp_mstatus_kept", 2'd0, 32'h0000_1880);
      release_redirect("bp");
      rd_check("bp_mstatus_after", 2'd0, 32'h0000_1880);

      // mret with single-cycle ready pulse
      wb_beat(1'b1, 2'd2, 32'h8000_0044, 1'b0, 1'b0, 32'h0);
      wb_beat(1'b0, 2'd0, 32'h0, 1'b0, 1'b1, 32'h8000_0044);
      check("mret_redirect_valid", {31'd0, CSR_redirect_valid}, 32'd1);
      check("mret_redirect_pc", CSR_redirect_pc, 32'h8000_0044);
      rd_check("mret_mstatus", 2'd0, 32'h0000_1888);
      release_redirect("mret");

      // ecall beats a simultaneous csr write
      wb_beat(1'b1, 2'd3, 32'hdead_beef, 1'b1, 1'b0, 32'h8000_0050);
      rd_check("prio_mcause", 2'd3, 32'd11);
      rd_check("prio_mepc", 2'd2, 32'h8000_0050);
      rd_check("prio_mstatus", 2'd0, 32'h0000_1880);
      check("prio_redirect_pc", CSR_redirect_pc, 32'h8000_0100);
      release_redirect("prio");

      // ecall beats mret when both are set
      wb_beat(1'b0, 2'd0, 32'h0, 1'b1, 1'b1, 32'h8000_0060);
      rd_check("both_mstatus", 2'd0, 32'h0000_1800);
      rd_check("both_mepc", 2'd2, 32'h8000_0060);
      check("both_redirect_pc", CSR_redirect_pc, 32'h8000_0100);
      release_redirect("both");

      // Same-cycle read of a register being written
      IDU_csr_rs = 2'd2;
      WB_valid = 1'b1; WB_csr_wen = 1'b1; WB_csr_rd = 2'd2; WB_csr_wdata = 32'h0000_1234;
      #1;
`ifdef CSR_WB_BYPASS_EN
      check("bypass_same_cycle", IDU_csr_rdata, 32'h0000_1234);
`else
      check("nobypass_same_cycle", IDU_csr_rdata, 32'h8000_0060);
`endif
      @(posedge clk); #1;
      WB_valid = 1'b0; WB_csr_wen = 1'b0;
      #1;
      check("wr_read_next_cycle", IDU_csr_rdata, 32'h0000_1234);

      // Reset asserted mid-redirect drops the request at once
      wb_beat(1'b0, 2'd0, 32'h0, 1'b1, 1'b0, 32'h8000_0070);
      check("pre_rst_valid", {31'd0, CSR_redirect_valid}, 32'd1);
      #2 rst = 1'b1;
      #1;
      check("midrst_valid", {31'd0, CSR_redirect_valid}, 32'd0);
      check("midrst_wb_ready", {31'd0, WB_ready}, 32'd1);
      rd_check("midrst_mepc", 2'd2, 32'h0);
      @(negedge clk); rst = 1'b0;

      $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
      $finish;
   end

endmodule
